// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl
// Operand-alignment sequencer for the FP add/sub path. It accepts two
// IEEE-754 operands, orders them by magnitude and right-shifts the smaller
// significand by the exponent difference, folding the lost bits into sticky.
// The aligned pair is then presented downstream over a valid/ready handshake.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        synchronous active-low reset
//   in_valid_i    operand pair valid
//   in_ready_o    block can accept a pair (only in IDLE)
//   op_a_i/op_b_i operands, packed {sign, exp, frac}
//   out_valid_o   aligned result valid (DONE)
//   out_ready_i   downstream accepts the result
//   big_sig_o     larger-magnitude significand {hidden, frac, G, R, S} with GRS=000
//   small_sig_o   aligned smaller significand, bit 0 is sticky
//   big_exp_o     effective exponent of the larger operand
//   big_sign_o    sign of the larger operand
//   small_sign_o  sign of the smaller operand
//   swap_o        1 when B had the larger magnitude
//
// Build option:
//   FP_ALIGN_BARREL_EN  when defined, CMP does the whole sticky-preserving
//                       shift in one cycle and the SHIFT state/counter are
//                       compiled out. Results are identical to the
//                       one-bit-per-cycle mode.

module fp_align_ctrl #(
  parameter int SIG_BITS = 23,
  parameter int EXP_BITS = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [SIG_BITS+EXP_BITS:0]   op_a_i,
  input  logic [SIG_BITS+EXP_BITS:0]   op_b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [SIG_BITS+3:0]          big_sig_o,
  output logic [SIG_BITS+3:0]          small_sig_o,
  output logic [EXP_BITS-1:0]          big_exp_o,
  output logic                         big_sign_o,
  output logic                         small_sign_o,
  output logic                         swap_o
);

  localparam int W    = SIG_BITS + 4;
  localparam int OP_W = SIG_BITS + EXP_BITS + 1;

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]     opA_q, opB_q;
  logic [W-1:0]        bigSig_q, smallSig_q;
  logic [EXP_BITS-1:0] bigExp_q;
  logic                bigSign_q, smallSign_q, swap_q;

  // Operand decode: denormals use effective exponent 1 and no hidden bit.
  logic [EXP_BITS-1:0] expA, expB, effExpA, effExpB;
  logic [W-1:0]        sigA, sigB, bigPre, smallPre, smallSat;
  logic [EXP_BITS:0]   expDiff;
  logic [EXP_BITS-1:0] absDiff;
  logic                borrow, swapNow, saturate;

  assign expA    = opA_q[OP_W-2:SIG_BITS];
  assign expB    = opB_q[OP_W-2:SIG_BITS];
  assign effExpA = (expA == '0) ? EXP_BITS'(1) : expA;
  assign effExpB = (expB == '0) ? EXP_BITS'(1) : expB;
  assign sigA    = {(expA != '0), opA_q[SIG_BITS-1:0], 3'b000};
  assign sigB    = {(expB != '0), opB_q[SIG_BITS-1:0], 3'b000};

  // The extra top bit of the difference is the borrow, i.e. eA < eB.
  assign expDiff  = {1'b0, effExpA} - {1'b0, effExpB};
  assign borrow   = expDiff[EXP_BITS];
  assign absDiff  = borrow ? (effExpB - effExpA) : expDiff[EXP_BITS-1:0];
  assign swapNow  = borrow || ((effExpA == effExpB) && (sigB > sigA));
  assign saturate = (32'(absDiff) >= W);

  assign bigPre   = swapNow ? sigB : sigA;
  assign smallPre = swapNow ? sigA : sigB;
  assign smallSat = {{(W-1){1'b0}}, |smallPre};

`ifdef FP_ALIGN_BARREL_EN
  // Single-cycle equivalent of n one-bit steps: bits above the shift move
  // down, and the new bit 0 is the OR of original bits [n:0].
  logic [W-1:0] shifted, lowMask, barrelSig;
  assign shifted   = smallPre >> absDiff;
  assign lowMask   = ~(({W{1'b1}} << absDiff) << 1);
  assign barrelSig = {shifted[W-1:1], |(smallPre & lowMask)};
`else
  localparam int CNT_W = $clog2(W);
  logic [CNT_W-1:0] cnt_q;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. A transfer out of DONE always returns to IDLE, so a
  // new pair can never be accepted in the same cycle as a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = CMP;
`ifdef FP_ALIGN_BARREL_EN
      CMP:  state_d = DONE;
`else
      CMP:  state_d = (absDiff == '0 || saturate) ? DONE : SHIFT;
      SHIFT: if (cnt_q == CNT_W'(1)) state_d = DONE;
`endif
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register. in_ready is forced
  // low while reset is asserted since the state is not yet known then.
  always_comb begin
    in_ready_o  = rst_ni && (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // Datapath: capture operands, resolve ordering in CMP, then shift the
  // smaller significand with sticky accumulation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      opA_q       <= '0;
      opB_q       <= '0;
      bigSig_q    <= '0;
      smallSig_q  <= '0;
      bigExp_q    <= '0;
      bigSign_q   <= 1'b0;
      smallSign_q <= 1'b0;
      swap_q      <= 1'b0;
`ifndef FP_ALIGN_BARREL_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            opA_q <= op_a_i;
            opB_q <= op_b_i;
          end
        end
        CMP: begin
          bigSig_q    <= bigPre;
          bigExp_q    <= swapNow ? effExpB : effExpA;
          bigSign_q   <= swapNow ? opB_q[OP_W-1] : opA_q[OP_W-1];
          smallSign_q <= swapNow ? opA_q[OP_W-1] : opB_q[OP_W-1];
          swap_q      <= swapNow;
`ifdef FP_ALIGN_BARREL_EN
          smallSig_q  <= saturate ? smallSat : barrelSig;
`else
          smallSig_q  <= saturate ? smallSat : smallPre;
          cnt_q       <= saturate ? '0 : CNT_W'(absDiff);
`endif
        end
`ifndef FP_ALIGN_BARREL_EN
        SHIFT: begin
          smallSig_q <= {1'b0, smallSig_q[W-1:2], smallSig_q[1] | smallSig_q[0]};
          cnt_q      <= cnt_q - CNT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign big_sig_o    = bigSig_q;
  assign small_sig_o  = smallSig_q;
  assign big_exp_o    = bigExp_q;
  assign big_sign_o   = bigSign_q;
  assign small_sign_o = smallSign_q;
  assign swap_o       = swap_q;

endmodule

// File: doc/fp_align_ctrl.md
# fp_align_ctrl

- Multi-cycle operand-alignment sequencer for the FP add/sub path.
- Accepts two IEEE-754 operands over a valid/ready handshake and orders them by magnitude (swap decision).
- Right-shifts the smaller significand by the exponent difference, one bit per cycle, collecting guard/round/sticky.
- Presents the aligned pair to the significand adder/normalizer stage over a second valid/ready handshake.

## Interface
- `SIG_BITS`, default 23: stored fraction width.
- `EXP_BITS`, default 8: exponent width.
- `W` (localparam) = `SIG_BITS`+4: aligned significand width, laid out as {hidden, fraction, G, R, S}.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `op_a`  in  1+`EXP_BITS`+`SIG_BITS`  operand A, packed {sign, exp, frac}.
- `op_b`  in  1+`EXP_BITS`+`SIG_BITS`  operand B, packed {sign, exp, frac}.
- `out_valid`  out  1  aligned result valid.
- `out_ready`  in  1  downstream accepts the result.
- `big_sig`  out  `W`  larger-magnitude significand with GRS bits = 000.
- `small_sig`  out  `W`  aligned smaller significand; bit 0 is sticky.
- `big_exp`  out  `EXP_BITS`  effective exponent of the larger operand.
- `big_sign`  out  1  sign of the larger operand.
- `small_sign`  out  1  sign of the smaller operand.
- `swap`  out  1  1 when B had the larger magnitude.

## Operation
- States: IDLE, CMP, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register both operands and go to CMP.
- CMP (1 cycle):
  - Effective exponent = `exp`==0 ? 1 : `exp`; hidden bit = (`exp`!=0).
  - Extended significand = {hidden, frac, 3'b000}.
  - Difference is computed EXP_BITS+1 wide, giving the borrow.
  - Swap rule: swap when eA<eB, or when eA==eB and sigB>sigA. Otherwise no swap; equal magnitudes do not swap.
  - Denormal-vs-normal at equal effective exponent swaps naturally through the significand compare.
  - Shift count n = |eA−eB|.
  - n==0: go to DONE.
  - n ≥ `W`: small becomes {0…0, OR of all small bits}, then go to DONE.
  - Otherwise: load the down-counter with n and go to SHIFT.
- SHIFT:
  - Each cycle: `small_sig` ← {0, `small_sig`[W-1:1]}, with new bit 0 = old bit1 | old bit0.
  - Counter decrements each cycle; on reaching 0, go to DONE.
- DONE:
  - `out_valid`=1 and all outputs held stable until `out_ready`=1.
  - On transfer, go to IDLE.
  - A new input is not accepted in the same cycle as a transfer.
- Zero, Inf and NaN get no special handling; they are aligned as ordinary encodings.
- Reset (any state, including mid-SHIFT or DONE): state→IDLE, counter=0.

## Timing
- Reset values:
  - `out_valid`=0, `big_sig`=0, `small_sig`=0, `big_exp`=0, `big_sign`=0, `small_sign`=0, `swap`=0.
  - `in_ready`=0 while `rst_n`=0, then 1 from the first cycle after release.
- `in_ready` is combinational from state (== IDLE). It does not depend on `in_valid`.
- Latency, counted from the accepting edge to `out_valid` high:
  - 1+k edges, where k = n for 0<n<`W`, else k=0.
  - Maximum k = `W`−1 = 26 at defaults.
- Throughput: one pair per (2+k) cycles minimum. Fixed-latency pipelining is not supported.
- Outputs are registered and change only on CMP/SHIFT updates or reset. They must not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `FP_ALIGN_BARREL_EN` defined:
  - CMP performs the full sticky-preserving right shift in one cycle with a barrel shifter.
  - The SHIFT state and counter are compiled out.
  - Latency is always 1 edge.
  - Results are bit-identical to the iterative mode.
- Not defined: iterative one-bit-per-cycle SHIFT, as described above.

## Test plan
- A=0x40400000, B=0x3F800000:
  - swap=0, big_exp=0x80, big_sig=0x6000000, small_sig=0x2000000.
  - `out_valid` 2 edges after accept (1 with barrel).
- A=0x3F800000, B=0x40400000:
  - swap=1, big_sig=0x6000000, small_sig=0x2000000.
  - big_sign/small_sign follow the swapped operands.
- A=0x3F800000, B=0x3FC00000 (equal exp):
  - swap=1, big_sig=0x6000000, small_sig=0x4000000, latency 1 edge.
- A=0x4B800000, B=0x3F800001 (n=24):
  - small_sig=0x0000005 (sticky set), latency 25 edges.
- A=0x50000000, B=0x3F800000 (n=33, saturate):
  - small_sig=0x0000001, latency 1 edge.
- A=0x00000001, B=0x00800000 (denormal vs normal, both effective exp 1):
  - swap=1, shift 0, big_exp=1.
- Hold `out_ready`=0 for 10 cycles in DONE: outputs stable, `in_ready`=0.
- Drop `rst_n` mid-SHIFT: next cycle `out_valid`=0 and all outputs 0; `in_ready`=1 after release.
